// File: rtl/digilock_pkg.sv
// Shared types and constants for the DigiLock event path.
package digilock_pkg;

  localparam logic [1:0] EV_UNLOCK_OK  = 2'b00;
  localparam logic [1:0] EV_WRONG_CODE = 2'b01;
  localparam logic [1:0] EV_ALARM      = 2'b10;
  localparam logic [1:0] EV_RELOCK     = 2'b11;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int ENTRY_W = 19;

  // One log entry, packed MSB-first as {code, hours, minutes, seconds}.
  typedef struct packed {
    logic [1:0]        code;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
  } entry_t;

endpackage

// File: rtl/log_ram.sv
// Register-array storage for the event log: one synchronous write port and
// one combinational read port.
module log_ram
  import digilock_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  // Store the incoming entry on the rising edge.
  // NOTE: storage has no reset; valid data is tracked by the pointers and count,
  // so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/event_logger.sv
// Circular log of timestamped lock events. Overwrites the oldest entry when
// full (raising a sticky overflow) and pops entries oldest-first with a
// one-cycle read latency.
module event_logger
  import digilock_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              event_valid,
  input  logic [1:0]        event_code,
  input  logic [SEC_W-1:0]  seconds,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [HOUR_W-1:0] hours,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [1:0]        rd_code,
  output logic [SEC_W-1:0]  rd_seconds,
  output logic [MIN_W-1:0]  rd_minutes,
  output logic [HOUR_W-1:0] rd_hours,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_accept;
  entry_t        wr_entry;
  entry_t        head_entry;
  entry_t        rd_entry;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // clear wins over both strobes; a pop from an empty log is dropped, so an
  // event and a pop in the same empty cycle never bypass each other.
  assign wr_en     = event_valid && !clear;
  assign rd_accept = rd_req && !empty && !clear;

  assign wr_entry = '{code: event_code, hours: hours, minutes: minutes, seconds: seconds};

  log_ram #(.DEPTH(DEPTH), .AW(AW)) u_log_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Pointer, occupancy and sticky overflow bookkeeping.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      // A write into a full log with no pop discards the oldest entry by
      // dragging the read pointer along with the write pointer.
      if (rd_accept || (wr_en && full)) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_accept && full) overflow <= 1'b1;
      unique case ({wr_en, rd_accept})
        2'b10:   if (!full) count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Register the popped entry; data holds between pops, valid pulses once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_entry <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_entry <= head_entry;
    end
  end

  assign rd_code    = rd_entry.code;
  assign rd_hours   = rd_entry.hours;
  assign rd_minutes = rd_entry.minutes;
  assign rd_seconds = rd_entry.seconds;

endmodule

// File: doc/event_logger.md
Name: event_logger

Overview:
- Sits directly downstream of clock_counter in the DigiLock datapath.
- Captures lock events (correct code, wrong code, alarm, relock) together with the current hours/minutes/seconds timestamp from clock_counter.
- Stores them in a circular log and lets the display/readout logic pop entries oldest-first.
- When the log is full, the oldest entry is overwritten and a sticky overflow flag is raised.

Parameters:
- DEPTH, 8, number of log entries (power of two, at least 2).
- AW, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- clear  input  1  synchronous flush of the log, including the overflow flag.
- event_valid  input  1  one-cycle strobe; each high cycle logs one event.
- event_code  input  2  event type: 00 unlock_ok, 01 wrong_code, 10 alarm, 11 relock.
- seconds  input  6  from clock_counter, range 0..59.
- minutes  input  6  from clock_counter, range 0..59.
- hours  input  5  from clock_counter, range 0..23.
- rd_req  input  1  request to pop the oldest entry.
- rd_valid  output  1  rd_* data valid; high for exactly one cycle.
- rd_code  output  2  code of the popped entry.
- rd_seconds  output  6  timestamp of the popped entry.
- rd_minutes  output  6  timestamp of the popped entry.
- rd_hours  output  5  timestamp of the popped entry.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; at least one entry has been lost.

Behaviour:
- Entry format is 19 bits: {code[1:0], hours[4:0], minutes[5:0], seconds[5:0]}.
- Reset (reset = 0, asynchronous): wr_ptr = rd_ptr = 0; count = 0; overflow = 0; rd_valid = 0; all rd_* data outputs = 0. Storage contents are don't-care.
- empty and full are combinational decodes of count.
- Write: in a cycle with event_valid = 1, the entry is formed from event_code and the timestamp inputs sampled at that same edge, then written at wr_ptr; wr_ptr increments and wraps at DEPTH.
- Read: in a cycle with rd_req = 1 and empty = 0, the entry at rd_ptr is registered to rd_* and rd_ptr increments. rd_valid = 1 in the following cycle (latency 1).
- rd_* data outputs hold their last value when rd_valid = 0.
- rd_req while empty: ignored; rd_valid stays 0; no error is raised.
- Boundary cases, per cycle (W = event_valid, R = rd_req accepted):
  - W only, not full: count +1.
  - W only, full: oldest entry is overwritten; rd_ptr +1 and wr_ptr +1; count stays at DEPTH; overflow set to 1.
  - R only: count -1.
  - W and R, not empty: the read returns the old oldest entry, the write is stored, count is unchanged, overflow is not set (including when full).
  - W and R while empty: the read is ignored (no write-through bypass); count becomes 1.
- clear = 1: pointers = 0, count = 0, overflow = 0, rd_valid = 0. clear has priority over W and R in the same cycle.
- overflow is cleared only by reset or clear.
- Reset asserted mid-operation: the log is lost immediately; all outputs take their reset values asynchronously.
- Timestamp inputs are assumed already stable in the clk domain; this block does no range checking and no synchronisation.
- No state machine beyond the pointer/count logic and the one-cycle rd_valid register.

Decomposition:
- Package digilock_pkg holds:
  - event code constants EV_UNLOCK_OK = 2'b00, EV_WRONG_CODE = 2'b01, EV_ALARM = 2'b10, EV_RELOCK = 2'b11;
  - widths SEC_W = 6, MIN_W = 6, HOUR_W = 5, ENTRY_W = 19.
- One sub-module, log_ram:
  - DEPTH x ENTRY_W register array;
  - one synchronous write port;
  - one combinational read port addressed by rd_ptr.
- Pointer, count and overflow logic stay in event_logger.

Test Plan:
- Reset, then no stimulus -> count = 0, empty = 1, full = 0, overflow = 0, rd_valid = 0.
- Log one event: event_code = 10 at 05:07:42, then pulse rd_req -> one cycle later rd_valid = 1 with rd_code = 10, rd_hours = 5, rd_minutes = 7, rd_seconds = 42; count returns to 0.
- Log 9 events with seconds = 0..8, no reads -> full = 1, overflow = 1, count = 8. Eight reads return seconds 1..8 in order; the ninth rd_req produces no rd_valid.
- With the log full, assert event_valid and rd_req in the same cycle -> returned entry is the oldest, count stays 8, overflow stays 0.
- While empty, assert event_valid and rd_req together -> rd_valid stays 0 and count = 1. Next, assert clear together with event_valid -> count = 0 and empty = 1.
- Log 3 entries, then pulse reset low mid-cycle -> count = 0 and rd_valid = 0 immediately (asynchronously); subsequent reads return nothing.
